// File: rtl/psum_writeback.sv
// Drains PE psums into the global buffer: overwrite, or saturating read-modify-write.
// Latency: 2 cycles per psum when overwriting, 3 when accumulating; finish one cycle after the last write.
// Backpressure: psum_ready is high only while waiting; optional ReLU on last pass via PSUM_WRITEBACK_RELU_EN.
module psum_writeback #(
  parameter int DATA_WIDTH        = 16,
  parameter int KB                = 32,
  parameter int SIZE_GLOBAL       = (KB * 8192) / DATA_WIDTH,
  parameter int ADDR_WIDTH_GLOBAL = $clog2(SIZE_GLOBAL)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         accumulate,
`ifdef PSUM_WRITEBACK_RELU_EN
  input  logic                         last_pass,
`endif
  input  logic [ADDR_WIDTH_GLOBAL-1:0] base_addr,
  input  logic [ADDR_WIDTH_GLOBAL-1:0] num_psums,
  input  logic signed [DATA_WIDTH-1:0] psum_in,
  input  logic                         psum_valid,
  output logic                         psum_ready,
  output logic                         gb_ren,
  output logic [ADDR_WIDTH_GLOBAL-1:0] gb_raddr,
  input  logic signed [DATA_WIDTH-1:0] gb_rdata,
  output logic                         gb_wen,
  output logic [ADDR_WIDTH_GLOBAL-1:0] gb_waddr,
  output logic signed [DATA_WIDTH-1:0] gb_wdata,
  output logic                         busy,
  output logic                         finish
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH_GLOBAL;
  localparam logic signed [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_WRITE, S_DONE} state_t;

  state_t               state, state_nxt;
  logic                 acc_q;
  logic                 relu_q;
  logic [AW-1:0]        addr_q, num_q, cnt_q;
  logic signed [DW-1:0] cap_q, sum_q;
  logic signed [DW:0]   sum_ext;
  logic signed [DW-1:0] sum_sat, wval;
  logic [AW:0]          cnt_inc;
  logic                 last_write;

  // One extra bit of headroom; disagreeing top bits mean the add overflowed.
  assign sum_ext = {cap_q[DW-1], cap_q} + {gb_rdata[DW-1], gb_rdata};
  always_comb begin
    sum_sat = sum_ext[DW-1:0];
    if (sum_ext[DW] != sum_ext[DW-1])
      sum_sat = sum_ext[DW] ? SAT_MIN : SAT_MAX;
  end

  assign cnt_inc    = {1'b0, cnt_q} + (AW+1)'(1);
  assign last_write = (cnt_inc == {1'b0, num_q});

  always_comb begin
    wval = acc_q ? sum_q : cap_q;
    if (relu_q && wval[DW-1])
      wval = '0;
  end

  assign gb_raddr = addr_q;
  assign gb_waddr = addr_q;
  assign gb_wdata = wval;
  assign busy     = (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    psum_ready = 1'b0;
    gb_ren     = 1'b0;
    gb_wen     = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start)
          state_nxt = (num_psums == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        psum_ready = 1'b1;
        if (psum_valid) begin
          gb_ren    = acc_q;
          state_nxt = acc_q ? S_READ : S_WRITE;
        end
      end
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: begin
        gb_wen    = 1'b1;
        state_nxt = last_write ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        finish    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q  <= 1'b0;
      relu_q <= 1'b0;
      addr_q <= '0;
      num_q  <= '0;
      cnt_q  <= '0;
      cap_q  <= '0;
      sum_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc_q  <= accumulate;
`ifdef PSUM_WRITEBACK_RELU_EN
            relu_q <= last_pass;
`else
            relu_q <= 1'b0;
`endif
            num_q  <= num_psums;
            addr_q <= base_addr;
            cnt_q  <= '0;
          end
        end
        S_WAIT:  if (psum_valid) cap_q <= psum_in;
        S_READ:  sum_q <= sum_sat;
        S_WRITE: begin
          // Natural overflow wraps the address around the buffer.
          addr_q <= addr_q + AW'(1);
          cnt_q  <= cnt_inc[AW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule
